// File: rtl/i2c_arb_pkg.sv
// Shared types and divider sizing helpers for the I2C command arbiter.
package i2c_arb_pkg;

   localparam int unsigned I2C_CMD_W = 24;

   typedef enum logic [1:0] {IDLE, WAIT, GAP, RESP} arb_state_e;

   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned i2c_freq);
      return clk_freq / i2c_freq;
   endfunction

   function automatic int unsigned calc_div_w(input int unsigned clk_freq,
                                              input int unsigned i2c_freq);
      int unsigned w;
      w = $clog2(calc_div(clk_freq, i2c_freq) + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// I2C controller work-clock divider: counts 0..DIV, toggles on wrap and
// flags the wrap cycle in which the work clock falls.
module i2c_clk_div
   import i2c_arb_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned I2C_FREQ = 400000
) (
   input  logic CLOCK_50,
   input  logic iRST_N,
   output logic ctrl_clk_o,
   output logic fall_tick_o
);

   localparam int unsigned DIV   = calc_div(CLK_FREQ, I2C_FREQ);
   localparam int unsigned DIV_W = calc_div_w(CLK_FREQ, I2C_FREQ);

   logic [DIV_W-1:0] cnt_q;
   logic             clk_q;
   logic             wrap;

   assign wrap = (cnt_q == DIV_W'(DIV));

   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         cnt_q <= '0;
         clk_q <= 1'b0;
      end else if (wrap) begin
         cnt_q <= '0;
         clk_q <= ~clk_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign ctrl_clk_o  = clk_q;
   assign fall_tick_o = wrap & clk_q;

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C_Controller among NUM_REQ requesters,
// with NACK retry. Optional WAIT timeout enabled by `define I2C_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 2,
   parameter int unsigned CLK_FREQ      = 50000000,
   parameter int unsigned I2C_FREQ      = 400000,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned TIMEOUT_TICKS = 64
) (
   input  logic                           CLOCK_50,
   input  logic                           iRST_N,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [I2C_CMD_W*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic                           rsp_err,
   output logic                           busy,
   output logic                           i2c_ctrl_clk,
   output logic [I2C_CMD_W-1:0]           i2c_data,
   output logic                           i2c_go,
   input  logic                           i2c_end,
   input  logic                           i2c_ack
);

   localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned RTY_W_C = $clog2(MAX_RETRY + 1);
   localparam int unsigned RTY_W   = (RTY_W_C == 0) ? 1 : RTY_W_C;

   logic                 fall_tick;
   arb_state_e           state_q;
   logic                 go_q;
   logic [I2C_CMD_W-1:0] data_q;
   logic [NUM_REQ-1:0]   ready_q;
   logic [NUM_REQ-1:0]   rsp_q;
   logic                 err_q;
   logic                 perr_q;
   logic [IDX_W-1:0]     last_q;
   logic [IDX_W-1:0]     grant_q;
   logic [NUM_REQ-1:0]   grant_oh_q;
   logic [RTY_W-1:0]     retry_q;

   logic [IDX_W-1:0]     win_d;
   logic [NUM_REQ-1:0]   win_oh_d;
   logic [I2C_CMD_W-1:0] win_data_d;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int unsigned TO_W_C = $clog2(TIMEOUT_TICKS + 1);
   localparam int unsigned TO_W   = (TO_W_C == 0) ? 1 : TO_W_C;
   logic [TO_W-1:0] to_q;
`endif

   i2c_clk_div #(
      .CLK_FREQ (CLK_FREQ),
      .I2C_FREQ (I2C_FREQ)
   ) u_clk_div (
      .CLOCK_50    (CLOCK_50),
      .iRST_N      (iRST_N),
      .ctrl_clk_o  (i2c_ctrl_clk),
      .fall_tick_o (fall_tick)
   );

   // Rotating search starting just after the most recently served requester.
   always_comb begin
      int unsigned                  idx;
      logic                         found;
      logic [NUM_REQ-1:0]           vsh;
      logic [I2C_CMD_W*NUM_REQ-1:0] dsh;
      win_d      = last_q;
      win_oh_d   = '0;
      win_data_d = '0;
      found      = 1'b0;
      idx        = 0;
      vsh        = '0;
      dsh        = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_q) + k) % NUM_REQ;
         vsh = req_valid >> idx;
         if (!found && vsh[0]) begin
            found      = 1'b1;
            win_d      = IDX_W'(idx);
            win_oh_d   = NUM_REQ'(1) << idx;
            dsh        = req_data >> (idx * I2C_CMD_W);
            win_data_d = dsh[I2C_CMD_W-1:0];
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= IDLE;
         go_q       <= 1'b0;
         data_q     <= '0;
         ready_q    <= '0;
         rsp_q      <= '0;
         err_q      <= 1'b0;
         perr_q     <= 1'b0;
         last_q     <= IDX_W'(NUM_REQ - 1);
         grant_q    <= '0;
         grant_oh_q <= '0;
         retry_q    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         to_q       <= '0;
`endif
      end else begin
         ready_q <= '0;
         rsp_q   <= '0;
         unique case (state_q)
            IDLE: begin
               if (fall_tick && |req_valid) begin
                  grant_q    <= win_d;
                  grant_oh_q <= win_oh_d;
                  data_q     <= win_data_d;
                  ready_q    <= win_oh_d;
                  go_q       <= 1'b1;
                  retry_q    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
                  to_q       <= '0;
`endif
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               if (fall_tick) begin
                  if (i2c_end) begin
                     go_q <= 1'b0;
                     if (!i2c_ack) begin
                        perr_q  <= 1'b0;
                        state_q <= RESP;
                     end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_q <= retry_q + 1'b1;
                        state_q <= GAP;
                     end else begin
                        perr_q  <= 1'b1;
                        state_q <= RESP;
                     end
                  end
`ifdef I2C_ARB_TIMEOUT_EN
                  else if (to_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                     go_q    <= 1'b0;
                     perr_q  <= 1'b1;
                     state_q <= RESP;
                  end else begin
                     to_q <= to_q + 1'b1;
                  end
`endif
               end
            end
            // GO held low across one controller rising edge before re-issue.
            GAP: begin
               if (fall_tick) begin
                  go_q    <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                  to_q    <= '0;
`endif
                  state_q <= WAIT;
               end
            end
            RESP: begin
               rsp_q   <= grant_oh_q;
               err_q   <= perr_q;
               last_q  <= grant_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_q;
   assign rsp_err   = err_q;
   assign busy      = (state_q != IDLE);
   assign i2c_go    = go_q;
   assign i2c_data  = data_q;

endmodule
